// File: rtl/conv2d_window_acc.sv
// Window accumulator: sums KERNEL_TAPS signed products plus a per-window bias,
// applies optional ReLU and saturation, and registers the result on a valid/ready output.
module conv2d_window_acc #(
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int KERNEL_TAPS = 9,
  parameter int RELU_EN     = 0
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        clr,
  input  logic signed [IN_WIDTH-1:0]  bias,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_vld,
  output logic                        in_rdy,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic                        busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
    return {{(ACC_WIDTH - IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] x);
    if ((RELU_EN != 0) && x[ACC_WIDTH-1]) return '0;
    return x;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] x);
    if (x > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (x < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return x[OUT_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0]     tap_cnt_q, tap_cnt_d;
  logic signed [IN_WIDTH-1:0]  bias_q, bias_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_vld_q, out_vld_d;

  logic                        is_last, is_first, take;
  logic signed [ACC_WIDTH-1:0] acc_base, tap_sum, win_sum;
  logic signed [IN_WIDTH-1:0]  bias_sel;

  always_comb begin
    is_last  = (tap_cnt_q == LAST);
    is_first = (tap_cnt_q == '0);
    // Only the final tap can stall, and only while an unconsumed result is held.
    in_rdy   = !(is_last && out_vld_q && !out_rdy);
    take     = in_vld && in_rdy && !clr;
    // A window starting at tap 0 ignores stale acc and uses the live bias.
    acc_base = is_first ? '0 : acc_q;
    bias_sel = is_first ? bias : bias_q;
    tap_sum  = acc_base + sext(in_data);
    win_sum  = tap_sum + sext(bias_sel);

    acc_d      = acc_q;
    tap_cnt_d  = tap_cnt_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;

    if (out_vld_q && out_rdy) out_vld_d = 1'b0;

    if (clr) begin
      acc_d     = '0;
      tap_cnt_d = '0;
    end else if (take) begin
      if (is_first) bias_d = bias;
      if (is_last) begin
        out_data_d = sat(relu(win_sum));
        out_vld_d  = 1'b1;
        acc_d      = '0;
        tap_cnt_d  = '0;
      end else begin
        acc_d     = tap_sum;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q      <= '0;
      tap_cnt_q  <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      tap_cnt_q  <= tap_cnt_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign busy     = (tap_cnt_q != '0);

endmodule

// File: doc/conv2d_window_acc.md
Name: conv2d_window_acc

Overview:
- Downstream consumer of the conv2D 8x8 signed multiplier stage.
- Receives one signed product per tap over a valid/ready stream and sums KERNEL_TAPS products per output pixel into a wide accumulator.
- Adds a per-window signed bias and optionally applies ReLU.
- Saturates the sum to OUT_WIDTH and presents it on a registered valid/ready output toward the line-buffer/writeback stage.

Parameters:
- IN_WIDTH, 8: signed product width (multiplier dout).
- ACC_WIDTH, 16: signed accumulator width; must satisfy ACC_WIDTH >= IN_WIDTH + ceil(log2(KERNEL_TAPS+1)) + 1.
- OUT_WIDTH, 8: signed output width after saturation.
- KERNEL_TAPS, 9: products per window (3x3 kernel); legal range 1..255.
- RELU_EN, 0: 1 clamps negative results to 0 before output.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort of the current partial window.
- bias  in  IN_WIDTH  signed bias; sampled when the first tap of a window is accepted.
- in_data  in  IN_WIDTH  signed product.
- in_vld  in  1  in_data valid.
- in_rdy  out  1  block can accept in_data this cycle.
- out_data  out  OUT_WIDTH  saturated signed result.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  downstream accepts out_data.
- busy  out  1  partial window in progress (tap_cnt != 0).

Behaviour:
- Reset (ap_rst=1, asynchronous): acc=0, tap_cnt=0, bias_q=0, out_data=0, out_vld=0, busy=0. in_rdy is combinational, so it evaluates to 1 while held in reset.
- Transfer rules:
  - Input transfer when in_vld && in_rdy.
  - Output transfer when out_vld && out_rdy.
  - out_data is held stable while out_vld=1 and out_rdy=0.
- State is tap_cnt (0..KERNEL_TAPS-1) plus the output register. There is no separate FSM; tap_cnt==0 means IDLE/first tap.
- in_rdy = NOT (tap_cnt==KERNEL_TAPS-1 AND out_vld AND NOT out_rdy).
  - Non-final taps are always accepted.
  - Only the final tap stalls on a full output register.
- On an accepted tap with tap_cnt==0:
  - bias_q <= bias.
  - acc <= sext(in_data).
  - If KERNEL_TAPS==1, treat it as the final tap.
- On an accepted intermediate tap: acc <= acc + sext(in_data); tap_cnt increments.
- On an accepted final tap:
  - sum = acc + sext(in_data) + sext(bias_q). If KERNEL_TAPS==1, use bias instead of bias_q.
  - If RELU_EN and sum<0, sum=0.
  - out_data <= clamp(sum, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
  - out_vld <= 1; acc <= 0; tap_cnt <= 0.
- Latency: out_vld rises on the cycle after the final tap is accepted (1 cycle).
- Output handshake:
  - On an output transfer with no simultaneous final tap, out_vld <= 0.
  - On an output transfer and a final-tap acceptance in the same cycle, out_vld stays 1 and out_data loads the new value. Back-to-back windows run at full rate with no bubble.
- All arithmetic is two's complement at ACC_WIDTH. Given the width rule, no intermediate wrap occurs; saturation applies only at the output.
- clr=1:
  - acc <= 0, tap_cnt <= 0.
  - Any in_data presented in that cycle is dropped, even if in_rdy=1.
  - The output register and out_vld are unaffected.
  - clr has priority over tap acceptance.
- Reset mid-window or with out_vld=1 discards the partial sum and the pending output immediately; no output is produced.
- busy = (tap_cnt != 0).

Test Plan:
- Basic sum: 9 taps of +1, bias=0, out_rdy=1 -> exactly one output, out_data=9, out_vld high one cycle after the 9th acceptance; busy high during taps 2..9.
- Saturation: 9 taps of +127, bias=+10 -> sum 1153, out_data=127. Then 9 taps of -128, bias=-1 -> out_data=-128. With RELU_EN=1 and taps of -5, bias=0 -> out_data=0.
- Backpressure: window A complete, out_rdy=0 -> next 8 taps accepted, in_rdy drops on the 9th. Raise out_rdy -> A (out_data=9 for all +1 taps) transfers in the same cycle the 9th tap is accepted; B appears the next cycle with no lost or duplicated data.
- Full-rate streaming: 4 windows, in_vld=1 and out_rdy=1 continuously with taps 1..9 and bias=-45 -> four outputs of 0, one every 9 cycles, in_rdy never low.
- clr mid-window: 4 taps of +3, then clr=1 with in_vld=1, then 9 taps of +2 with bias=1 -> single output 19; the clr-cycle tap is ignored.
- Async reset: assert ap_rst between clock edges mid-window with out_vld=1 -> out_vld, busy and out_data go to 0 without a clock edge. After release, 9 taps of +1 give 9.
